mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master arbiter that shares the single pulse-request memory port between the x3q16 core (port 0) and a second master (port 1), such as the planned UART loader or debug DMA.
- Each master keeps the core's existing handshake unchanged:
  - one-cycle `request` carrying address, type and data;
  - completion via `memory_ready` (read) or `write_complete` (write).
- The arbiter latches each request, grants round-robin, and issues one transaction at a time to memory.
- It routes the completion only to the owning master, with a timeout watchdog so a hung memory cannot lock up the system.

Parameters:
- TIMEOUT, 1024: number of WAIT cycles without a memory response before the transaction is force-completed.
- TW, 11: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_request, m1_request  in  1  one-cycle request pulse from master 0 / master 1.
- m0_request_type, m1_request_type  in  1  0 = read, 1 = write.
- m0_request_address, m1_request_address  in  16  target address.
- m0_data_out, m1_data_out  in  16  write data.
- m0_memory_ready, m1_memory_ready  out  1  one-cycle read-complete strobe to the master.
- m0_write_complete, m1_write_complete  out  1  one-cycle write-complete strobe to the master.
- m0_memory_in, m1_memory_in  out  16  read data; valid while the matching memory_ready is high.
- mem_request  out  1  one-cycle request pulse to memory.
- mem_request_type  out  1  request type to memory.
- mem_request_address  out  16  address to memory.
- mem_data_out  out  16  write data to memory.
- mem_memory_ready  in  1  memory read-done strobe.
- mem_write_complete  in  1  memory write-done strobe.
- mem_memory_in  in  16  memory read data.
- busy  out  1  high while a transaction is outstanding (state WAIT).
- timeout_err  out  1  sticky flag: set when any transaction times out.

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0, state IDLE, pending flags cleared, timeout counter 0, timeout_err 0;
  - last_grant = 1, so port 0 wins the first tie.
- Capture:
  - mX_request=1 with pending_X=0 latches addr/type/data into slot X and sets pending_X on the next edge.
  - mX_request while pending_X=1 is ignored (first request wins; nothing is overwritten or queued).
- IDLE:
  - If any pending flag is set, grant by round-robin: the port not equal to last_grant wins a tie; otherwise the sole pending port wins.
  - On grant, register mem_request=1 plus the slot's fields, record the owner, clear the counter, go to WAIT.
  - Strobes arriving on mem_memory_ready / mem_write_complete in IDLE are ignored.
- WAIT:
  - mem_request is high only during the first WAIT cycle; mem_request_type/address/data_out hold their values throughout WAIT.
  - Completion condition: (type=0 and mem_memory_ready) or (type=1 and mem_write_complete). A strobe that does not match the type is ignored.
  - On completion, on the next edge:
    - owner's mX_memory_ready (read) or mX_write_complete (write) = 1 for exactly one cycle;
    - mX_memory_in = registered mem_memory_in for reads;
    - clear pending_owner, set last_grant = owner, go to IDLE.
  - Timeout: the counter increments on each WAIT cycle without completion. When it reaches TIMEOUT-1 without completion:
    - force-complete with data 0x0000;
    - the strobe type matches the request type;
    - set timeout_err;
    - go to IDLE.
- Latency:
  - mX_request at cycle N → mem_request at cycle N+2 when idle.
  - Memory strobe at cycle M → master strobe at cycle M+1.
  - Back-to-back grants are separated by at least one IDLE cycle.
- Outputs outside completion:
  - mX_memory_in holds its last value;
  - non-owner strobes are always 0; both ports never strobe in the same cycle.
- Simultaneous events: capture of a new request on port X in the same cycle as X's completion sets pending_X (set wins over clear).
- Reset mid-WAIT: the transaction is abandoned, no master strobe is issued, and a late memory strobe after reset is ignored.
- timeout_err stays set until reset.

Test Plan:
1. Single read, port 0: m0 request addr 0x0010 at cycle 0 → mem_request=1, addr 0x0010, type 0 at cycle 2; mem_memory_ready with data 0xBEEF at cycle 5 → m0_memory_ready=1 and m0_memory_in=0xBEEF at cycle 6, m1 strobes stay 0, busy falls.
2. Tie after reset: m0 (0x0100) and m1 (0x0200) request in the same cycle → 0x0100 is issued first, then 0x0200 after the first completes. A second simultaneous pair → port 0 first again (last_grant=1); strobes go only to the owner.
3. Write, port 1: addr 0x2000, data 0x1234, type 1 → mem_request_type=1 and mem_data_out=0x1234. A stray mem_memory_ready is ignored; mem_write_complete → m1_write_complete pulses for exactly one cycle.
4. Timeout with TIMEOUT=16: read with no memory response → m0_memory_ready with data 0x0000 at the WAIT-exit edge, timeout_err=1 and staying set. The next request is served normally.
5. Reset asserted during WAIT, then mem_memory_ready 3 cycles after release → no master strobe, state IDLE, all outputs 0.
6. m0 issues a second request while pending → only one mem_request is issued and exactly one m0 strobe is returned.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pulse-request memory port between two masters.
// Each master's request is latched into its own slot; slots are granted
// round-robin and one transaction at a time is sent to memory. The
// completion strobe goes back to the owning master only. A watchdog
// force-completes (data 0) a transaction that memory never answers.
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   mX_request/_type      one-cycle request pulse, 0=read 1=write
//   mX_request_address    target address
//   mX_data_out           write data
//   mX_memory_ready       one-cycle read-complete strobe
//   mX_write_complete     one-cycle write-complete strobe
//   mX_memory_in          read data, held between completions
//   mem_request/_type     one-cycle request pulse / type to memory
//   mem_request_address   address to memory, held during WAIT
//   mem_data_out          write data to memory, held during WAIT
//   mem_memory_ready      memory read-done strobe
//   mem_write_complete    memory write-done strobe
//   mem_memory_in         memory read data
//   busy                  a transaction is outstanding
//   timeout_err           sticky, set when any transaction times out
module mem_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_request,
    input  logic        m0_request_type,
    input  logic [15:0] m0_request_address,
    input  logic [15:0] m0_data_out,
    output logic        m0_memory_ready,
    output logic        m0_write_complete,
    output logic [15:0] m0_memory_in,
    input  logic        m1_request,
    input  logic        m1_request_type,
    input  logic [15:0] m1_request_address,
    input  logic [15:0] m1_data_out,
    output logic        m1_memory_ready,
    output logic        m1_write_complete,
    output logic [15:0] m1_memory_in,
    output logic        mem_request,
    output logic        mem_request_type,
    output logic [15:0] mem_request_address,
    output logic [15:0] mem_data_out,
    input  logic        mem_memory_ready,
    input  logic        mem_write_complete,
    input  logic [15:0] mem_memory_in,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       slot_type_q, slot_type_d;
    logic [1:0][15:0] slot_addr_q, slot_addr_d;
    logic [1:0][15:0] slot_data_q, slot_data_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_type_q, mem_type_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic [15:0]      mem_wdata_q, mem_wdata_d;
    logic [1:0]       rdy_q, rdy_d;
    logic [1:0]       wc_q, wc_d;
    logic [1:0][15:0] rdata_q, rdata_d;
    logic             terr_q, terr_d;

    logic [1:0]       req;
    logic [1:0]       req_type;
    logic [1:0][15:0] req_addr;
    logic [1:0][15:0] req_data;
    logic [1:0]       clr;
    logic             gnt;
    logic             done;
    logic             expired;

    assign req      = {m1_request, m0_request};
    assign req_type = {m1_request_type, m0_request_type};
    assign req_addr = {m1_request_address, m0_request_address};
    assign req_data = {m1_data_out, m0_data_out};

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        slot_type_d  = slot_type_q;
        slot_addr_d  = slot_addr_q;
        slot_data_d  = slot_data_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        mem_req_d    = 1'b0;
        mem_type_d   = mem_type_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdy_d        = 2'b00;
        wc_d         = 2'b00;
        rdata_d      = rdata_q;
        terr_d       = terr_q;
        clr          = 2'b00;
        gnt          = 1'b0;
        done         = 1'b0;
        expired      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    // On a tie the port that did not win last time goes.
                    gnt         = (pend_q == 2'b11) ? ~last_grant_q
                                                    : pend_q[1];
                    mem_req_d   = 1'b1;
                    mem_type_d  = slot_type_q[gnt];
                    mem_addr_d  = slot_addr_q[gnt];
                    mem_wdata_d = slot_data_q[gnt];
                    owner_d     = gnt;
                    cnt_d       = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // Only the strobe matching the request type completes.
                done    = mem_type_q ? mem_write_complete
                                     : mem_memory_ready;
                expired = (cnt_q == TW'(TIMEOUT - 1));
                if (done || expired) begin
                    if (mem_type_q) begin
                        wc_d[owner_q] = 1'b1;
                    end else begin
                        rdy_d[owner_q]   = 1'b1;
                        rdata_d[owner_q] = done ? mem_memory_in
                                                : 16'h0000;
                    end
                    if (!done) begin
                        terr_d = 1'b1;
                    end
                    clr[owner_q] = 1'b1;
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture runs after the completion clear so that a new request
        // landing on its own port's completion cycle is kept.
        for (int p = 0; p < 2; p++) begin
            if (clr[p]) begin
                pend_d[p] = 1'b0;
            end
            if (req[p] && (!pend_q[p] || clr[p])) begin
                pend_d[p]      = 1'b1;
                slot_type_d[p] = req_type[p];
                slot_addr_d[p] = req_addr[p];
                slot_data_d[p] = req_data[p];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pend_q       <= 2'b00;
            slot_type_q  <= 2'b00;
            slot_addr_q  <= '0;
            slot_data_q  <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_type_q   <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 16'h0000;
            rdy_q        <= 2'b00;
            wc_q         <= 2'b00;
            rdata_q      <= '0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            slot_type_q  <= slot_type_d;
            slot_addr_q  <= slot_addr_d;
            slot_data_q  <= slot_data_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_type_q   <= mem_type_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdy_q        <= rdy_d;
            wc_q         <= wc_d;
            rdata_q      <= rdata_d;
            terr_q       <= terr_d;
        end
    end

    assign m0_memory_ready     = rdy_q[0];
    assign m1_memory_ready     = rdy_q[1];
    assign m0_write_complete   = wc_q[0];
    assign m1_write_complete   = wc_q[1];
    assign m0_memory_in        = rdata_q[0];
    assign m1_memory_in        = rdata_q[1];
    assign mem_request         = mem_req_q;
    assign mem_request_type    = mem_type_q;
    assign mem_request_address = mem_addr_q;
    assign mem_data_out        = mem_wdata_q;
    assign busy                = (state_q == WAIT);
    assign timeout_err         = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed traffic on both masters, a random
// memory responder, and a transaction-level scoreboard for mem_arbiter.
module tb_mem_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_request, m1_request;
    logic        m0_request_type, m1_request_type;
    logic [15:0] m0_request_address, m1_request_address;
    logic [15:0] m0_data_out, m1_data_out;
    logic        m0_memory_ready, m1_memory_ready;
    logic        m0_write_complete, m1_write_complete;
    logic [15:0] m0_memory_in, m1_memory_in;
    logic        mem_request, mem_request_type;
    logic [15:0] mem_request_address, mem_data_out;
    logic        mem_memory_ready, mem_write_complete;
    logic [15:0] mem_memory_in;
    logic        busy, timeout_err;

    mem_arbiter #(.TIMEOUT(TO), .TW(5)) dut (
        .clk                 (clk),
        .reset               (reset),
        .m0_request          (m0_request),
        .m0_request_type     (m0_request_type),
        .m0_request_address  (m0_request_address),
        .m0_data_out         (m0_data_out),
        .m0_memory_ready     (m0_memory_ready),
        .m0_write_complete   (m0_write_complete),
        .m0_memory_in        (m0_memory_in),
        .m1_request          (m1_request),
        .m1_request_type     (m1_request_type),
        .m1_request_address  (m1_request_address),
        .m1_data_out         (m1_data_out),
        .m1_memory_ready     (m1_memory_ready),
        .m1_write_complete   (m1_write_complete),
        .m1_memory_in        (m1_memory_in),
        .mem_request         (mem_request),
        .mem_request_type    (mem_request_type),
        .mem_request_address (mem_request_address),
        .mem_data_out        (mem_data_out),
        .mem_memory_ready    (mem_memory_ready),
        .mem_write_complete  (mem_write_complete),
        .mem_memory_in       (mem_memory_in),
        .busy                (busy),
        .timeout_err         (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Issued requests (written by stimulus only).
    int          iss_cnt [2] = '{0, 0};
    int          req_cyc [2] = '{0, 0};
    logic        req_typ [2];
    logic [15:0] req_addr [2];
    logic [15:0] req_dat [2];

    // Completions seen (written by monitor only).
    int done_cnt [2] = '{0, 0};

    // Expected responses pushed by the memory responder.
    logic        exp_typ [256];
    logic [15:0] exp_dat [256];
    int          exp_due [256];
    bit          exp_to  [256];
    int          wr_idx = 0;

    // Controls written by the main sequence only.
    bit resp_off = 1'b0;
    bit force_to = 1'b0;
    int late_cyc = -1;

    bit in_wait = 1'b0;

    logic [71:0] all_out;
    assign all_out = {m0_memory_ready, m1_memory_ready,
                      m0_write_complete, m1_write_complete,
                      m0_memory_in, m1_memory_in,
                      mem_request, mem_request_type,
                      mem_request_address, mem_data_out,
                      busy, timeout_err};

    function automatic bit pend(input int p);
        return iss_cnt[p] != done_cnt[p];
    endfunction

    // ---------------- memory responder ----------------
    bit          r_act = 1'b0;
    bit          r_to, r_stray;
    logic        r_typ;
    int          r_g, r_d;
    int          r_idle = -1;

    initial begin : responder
        mem_memory_ready   = 1'b0;
        mem_write_complete = 1'b0;
        mem_memory_in      = 16'h0000;
        forever begin
            @(negedge clk);
            #1;
            mem_memory_ready   = 1'b0;
            mem_write_complete = 1'b0;
            mem_memory_in      = 16'($urandom);
            if (!reset) begin
                r_act  = 1'b0;
                r_idle = -1;
            end else begin
                if (cyc == late_cyc) mem_memory_ready = 1'b1;
                if (mem_request && !resp_off) begin
                    r_act   = 1'b1;
                    r_typ   = mem_request_type;
                    r_g     = cyc;
                    r_to    = force_to || ($urandom_range(0, 9) == 0);
                    r_d     = $urandom_range(0, 4);
                    r_stray = 1'($urandom_range(0, 1));
                    if (r_to) begin
                        exp_typ[wr_idx % 256] = r_typ;
                        exp_dat[wr_idx % 256] = 16'h0000;
                        exp_due[wr_idx % 256] = r_g + TO;
                        exp_to[wr_idx % 256]  = 1'b1;
                        wr_idx++;
                    end
                end
                if (r_act) begin
                    if (r_to) begin
                        // Wrong-type strobe only; must not complete.
                        if (r_stray && cyc == r_g + 2) begin
                            mem_memory_ready   = r_typ;
                            mem_write_complete = !r_typ;
                        end
                        if (cyc == r_g + TO) r_act = 1'b0;
                    end else if (cyc == r_g + r_d) begin
                        mem_memory_ready   = !r_typ;
                        mem_write_complete = r_typ;
                        exp_typ[wr_idx % 256] = r_typ;
                        exp_dat[wr_idx % 256] = mem_memory_in;
                        exp_due[wr_idx % 256] = cyc + 1;
                        exp_to[wr_idx % 256]  = 1'b0;
                        wr_idx++;
                        r_act  = 1'b0;
                        r_idle = r_stray ? cyc + 1 : -1;
                    end else if (r_stray && cyc == r_g) begin
                        mem_memory_ready   = r_typ;
                        mem_write_complete = !r_typ;
                    end
                end else if (cyc == r_idle) begin
                    // Strobe while the arbiter is idle: ignored.
                    mem_memory_ready   = 1'b1;
                    mem_write_complete = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          own_q [$];
    int          rd_idx = 0;
    int          last_grant = 1;
    int          last_done = -100;
    bit          exp_terr = 1'b0;
    logic [15:0] mem_in_exp [2] = '{16'h0, 16'h0};
    logic [32:0] g_fields;
    int          g_cyc = 0;

    initial begin : monitor
        logic [1:0]  st_r, st_w, elig;
        logic [32:0] want;
        logic [15:0] rdat;
        bit          exp_req;
        int          p, w, idx, e_own;
        forever begin
            @(negedge clk);
            if (!reset) begin
                checks++;
                if (all_out !== 72'h0) begin
                    errors++;
                    $display("FAIL reset_outputs got %h exp 0", all_out);
                end
                in_wait    = 1'b0;
                rd_idx     = wr_idx;
                own_q.delete();
                done_cnt   = iss_cnt;
                last_grant = 1;
                last_done  = -100;
                exp_terr   = 1'b0;
                mem_in_exp = '{16'h0, 16'h0};
            end else begin
                st_r = {m1_memory_ready, m0_memory_ready};
                st_w = {m1_write_complete, m0_write_complete};
                if ($countones({st_r, st_w}) > 1) begin
                    checks++;
                    errors++;
                    $display("FAIL multi_strobe got r=%b w=%b", st_r, st_w);
                end else if (|{st_r, st_w}) begin
                    checks++;
                    p    = (st_r[1] | st_w[1]) ? 1 : 0;
                    rdat = (p == 0) ? m0_memory_in : m1_memory_in;
                    if (rd_idx == wr_idx || own_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_strobe port %0d cyc %0d",
                                 p, cyc);
                    end else begin
                        e_own = own_q.pop_front();
                        idx   = rd_idx % 256;
                        rd_idx++;
                        if (exp_to[idx]) exp_terr = 1'b1;
                        if (p != e_own || st_w[p] != exp_typ[idx] ||
                            cyc != exp_due[idx] ||
                            (!exp_typ[idx] && rdat !== exp_dat[idx])) begin
                            errors++;
                            $display("FAIL completion got p%0d w%0d c%0d d%h exp p%0d w%0d c%0d d%h",
                                     p, st_w[p], cyc, rdat, e_own,
                                     exp_typ[idx], exp_due[idx],
                                     exp_dat[idx]);
                        end
                        if (!exp_typ[idx]) mem_in_exp[e_own] = exp_dat[idx];
                        done_cnt[e_own] = iss_cnt[e_own];
                        last_grant      = e_own;
                        last_done       = cyc;
                        in_wait         = 1'b0;
                    end
                end

                // Grant prediction: a request issued at cycle k may be
                // granted no earlier than k+2, and the arbiter must have
                // been idle the cycle before.
                elig = 2'b00;
                for (int q = 0; q < 2; q++) begin
                    if (pend(q) && req_cyc[q] <= cyc - 2) elig[q] = 1'b1;
                end
                exp_req = !in_wait && (last_done <= cyc - 1) && (|elig);
                if (mem_request || exp_req) begin
                    checks++;
                    if (!exp_req) begin
                        errors++;
                        $display("FAIL spurious_grant cyc %0d addr %h",
                                 cyc, mem_request_address);
                    end else if (!mem_request) begin
                        errors++;
                        $display("FAIL missing_grant cyc %0d got 0 exp 1",
                                 cyc);
                    end else begin
                        w = (elig == 2'b11) ? 1 - last_grant
                                            : (elig[1] ? 1 : 0);
                        want = {req_typ[w], req_addr[w], req_dat[w]};
                        if ({mem_request_type, mem_request_address,
                             mem_data_out} !== want) begin
                            errors++;
                            $display("FAIL grant got %h exp %h (port %0d)",
                                     {mem_request_type, mem_request_address,
                                      mem_data_out}, want, w);
                        end
                        own_q.push_back(w);
                        in_wait  = 1'b1;
                        g_fields = want;
                        g_cyc    = cyc;
                    end
                end

                checks++;
                if (busy !== in_wait) begin
                    errors++;
                    $display("FAIL busy got %b exp %b cyc %0d",
                             busy, in_wait, cyc);
                end
                if (in_wait && cyc > g_cyc) begin
                    checks++;
                    if (mem_request !== 1'b0 ||
                        {mem_request_type, mem_request_address,
                         mem_data_out} !== g_fields) begin
                        errors++;
                        $display("FAIL wait_hold got %b %h exp 0 %h",
                                 mem_request,
                                 {mem_request_type, mem_request_address,
                                  mem_data_out}, g_fields);
                    end
                end

                checks++;
                if (m0_memory_in !== mem_in_exp[0] ||
                    m1_memory_in !== mem_in_exp[1]) begin
                    errors++;
                    $display("FAIL memory_in got %h %h exp %h %h",
                             m0_memory_in, m1_memory_in,
                             mem_in_exp[0], mem_in_exp[1]);
                end

                checks++;
                if (timeout_err !== exp_terr) begin
                    errors++;
                    $display("FAIL timeout_err got %b exp %b cyc %0d",
                             timeout_err, exp_terr, cyc);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #2;
        m0_request = 1'b0;
        m1_request = 1'b0;
    endtask

    task automatic issue(input int p, input logic t,
                         input logic [15:0] a, input logic [15:0] d,
                         input bit dup);
        if (p == 0) begin
            m0_request         = 1'b1;
            m0_request_type    = t;
            m0_request_address = a;
            m0_data_out        = d;
        end else begin
            m1_request         = 1'b1;
            m1_request_type    = t;
            m1_request_address = a;
            m1_data_out        = d;
        end
        if (!dup) begin
            req_typ[p]  = t;
            req_addr[p] = a;
            req_dat[p]  = d;
            req_cyc[p]  = cyc;
            iss_cnt[p]++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pend(0) || pend(1) || in_wait) && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL drain_timeout got busy %b exp idle", busy);
        end
    endtask

    initial begin : main
        int n;
        reset              = 1'b0;
        m0_request         = 1'b0;
        m1_request         = 1'b0;
        m0_request_type    = 1'b0;
        m1_request_type    = 1'b0;
        m0_request_address = 16'h0;
        m1_request_address = 16'h0;
        m0_data_out        = 16'h0;
        m1_data_out        = 16'h0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        tick();

        // single read on port 0
        issue(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
        drain();

        // two simultaneous pairs: port 0 wins both ties
        for (int k = 0; k < 2; k++) begin
            tick();
            issue(0, 1'b0, 16'h0100, 16'h0000, 1'b0);
            issue(1, 1'b0, 16'h0200, 16'h0000, 1'b0);
            drain();
        end

        // write on port 1
        tick();
        issue(1, 1'b1, 16'h2000, 16'h1234, 1'b0);
        drain();

        // forced timeout, then a normal transaction
        force_to = 1'b1;
        tick();
        issue(0, 1'b0, 16'h0030, 16'h0000, 1'b0);
        drain();
        force_to = 1'b0;
        tick();
        issue(0, 1'b0, 16'h0040, 16'h0000, 1'b0);
        drain();

        // second request while pending is dropped
        tick();
        issue(0, 1'b0, 16'h0050, 16'h0000, 1'b0);
        tick();
        issue(0, 1'b1, 16'h0051, 16'h5555, 1'b1);
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (!pend(p) && $urandom_range(0, 3) == 0) begin
                    issue(p, 1'($urandom), 16'($urandom),
                          16'($urandom), 1'b0);
                end else if (pend(p) && req_cyc[p] == cyc - 1 &&
                             $urandom_range(0, 1) == 0) begin
                    issue(p, 1'($urandom), 16'($urandom),
                          16'($urandom), 1'b1);
                end
            end
        end
        drain();

        // reset while a read is outstanding, then a late memory strobe
        resp_off = 1'b1;
        tick();
        issue(0, 1'b0, 16'h0060, 16'h0000, 1'b0);
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (!busy) begin
            errors++;
            $display("FAIL reset_wait_busy got 0 exp 1");
        end
        reset = 1'b0;
        tick();
        tick();
        reset    = 1'b1;
        late_cyc = cyc + 3;
        repeat (6) tick();
        checks++;
        if (all_out !== 72'h0) begin
            errors++;
            $display("FAIL after_reset got %h exp 0", all_out);
        end
        resp_off = 1'b0;

        // normal service after reset
        tick();
        issue(1, 1'b0, 16'h0070, 16'h0000, 1'b0);
        drain();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
